// File: rtl/rs_issue_arbiter.sv
// rs_issue_arbiter
//
// Issue arbiter for one 16-entry reservation station. Reduces the per-entry
// ready vector to a single any-ready flag, picks one entry with a rotating
// round-robin pointer and offers it to the functional unit over a
// valid/ready handshake. The offer is held until it is accepted, cancelled
// (entry squashed in place) or flushed.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   req[15:0]    per-entry ready-to-issue
//   flush        synchronous pipeline flush
//   any_req      combinational OR of req
//   issue_valid  registered; an offer is present
//   issue_ready  functional unit accepts the offer this cycle
//   issue_grant  registered one-hot grant, zero when idle
//   issue_idx    binary index of issue_grant, zero when idle
//   issue_fire   combinational issue_valid & issue_ready
//   stall_cnt    saturating count of cycles with an offer but no accept
//
// Optional feature macro: RS_ISSUE_ARB_STALL_CNT_EN
//   defined   : stall_cnt is a live saturating counter, cleared only by reset
//   undefined : stall_cnt is tied to zero and no counter logic exists

module rs_issue_arbiter #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             flush,
  output logic             any_req,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [N-1:0]     issue_grant,
  output logic [IDX_W-1:0] issue_idx,
  output logic             issue_fire,
  output logic [15:0]      stall_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state_q, state_nxt;
  logic [N-1:0]     grant_q, grant_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [IDX_W-1:0] ptr_q, ptr_nxt;

  logic [IDX_W:0]   pick_idle;
  logic [IDX_W:0]   pick_next;
  logic [IDX_W-1:0] next_ptr;

  // Scan from 'start' upwards with wrap-around; the first set bit wins.
  // Result is {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] vec,
                                             input logic [IDX_W-1:0] start);
    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++) begin
      cand = start + IDX_W'(i);
      if (!found && vec[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    return {found, win};
  endfunction

  assign any_req     = |req;
  assign issue_valid = (state_q == OFFER);
  assign issue_grant = grant_q;
  assign issue_idx   = idx_q;
  assign issue_fire  = issue_valid & issue_ready;

  // After a fire the pointer moves just past the fired entry, and the
  // re-arbitration masks the fired entry because the RS may still be
  // showing its req bit for one more cycle.
  assign next_ptr  = idx_q + 1'b1;
  assign pick_idle = rr_pick(req, ptr_q);
  assign pick_next = rr_pick(req & ~grant_q, next_ptr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_nxt;
      grant_q <= grant_nxt;
      idx_q   <= idx_nxt;
      ptr_q   <= ptr_nxt;
    end
  end

  // Flush beats cancel beats fire. A flush coinciding with a fire still
  // lets the fire count (the FU has sampled it) but the pointer stays put,
  // so the next arbitration restarts from the old position.
  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    idx_nxt   = idx_q;
    ptr_nxt   = ptr_q;
    case (state_q)
      IDLE: begin
        if (any_req && !flush) begin
          state_nxt = OFFER;
          idx_nxt   = pick_idle[IDX_W-1:0];
          grant_nxt = {{(N-1){1'b0}}, 1'b1} << pick_idle[IDX_W-1:0];
        end
      end
      OFFER: begin
        if (flush || (!req[idx_q] && !issue_ready)) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          idx_nxt   = '0;
        end else if (issue_fire) begin
          ptr_nxt = next_ptr;
          if (pick_next[IDX_W]) begin
            idx_nxt   = pick_next[IDX_W-1:0];
            grant_nxt = {{(N-1){1'b0}}, 1'b1} << pick_next[IDX_W-1:0];
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
            idx_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        idx_nxt   = '0;
      end
    endcase
  end

`ifdef RS_ISSUE_ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (issue_valid && !issue_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// tb_rs_issue_arbiter
//
// Directed bench for rs_issue_arbiter. Each stimulus step pushes the
// registered outputs it should produce onto a scoreboard queue; the entry is
// popped and compared just after the following rising edge. Combinational
// outputs are checked once the step's inputs have settled.
// Honours RS_ISSUE_ARB_STALL_CNT_EN for the stall counter expectations.

module tb_rs_issue_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] req = 16'h0000;
  logic        flush = 1'b0;
  logic        issue_ready = 1'b0;
  logic        any_req;
  logic        issue_valid;
  logic [15:0] issue_grant;
  logic [3:0]  issue_idx;
  logic        issue_fire;
  logic [15:0] stall_cnt;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    logic       valid;
    logic [3:0] idx;
  } exp_t;

  exp_t sb[$];

  rs_issue_arbiter #(.N(16), .IDX_W(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .flush(flush),
    .any_req(any_req),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_grant(issue_grant),
    .issue_idx(issue_idx),
    .issue_fire(issue_fire),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic collect();
    exp_t        e;
    logic [15:0] g;
    checkOutput("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = e.valid ? (16'h0001 << e.idx) : 16'h0000;
      checkOutput({e.tag, "_valid"}, issue_valid, e.valid);
      checkOutput({e.tag, "_idx"},   issue_idx,   e.valid ? e.idx : 4'd0);
      checkOutput({e.tag, "_grant"}, issue_grant, g);
    end
  endtask

  // Called just after a rising edge; drives one cycle of inputs.
  task automatic applyStimulus(input string tag, input logic [15:0] r, input logic rdy,
                               input logic fl, input logic exp_fire,
                               input logic exp_valid, input logic [3:0] exp_idx);
    exp_t e;
    req = r;
    issue_ready = rdy;
    flush = fl;
    #1;
    checkOutput({tag, "_any"},  any_req,    |r);
    checkOutput({tag, "_fire"}, issue_fire, exp_fire);
    e.tag = tag;
    e.valid = exp_valid;
    e.idx = exp_idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    collect();
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    req = 16'hFFFF;
    issue_ready = 1'b1;
    flush = 1'b0;
    #2;
    checkOutput("rst_valid", issue_valid, 0);
    checkOutput("rst_grant", issue_grant, 0);
    checkOutput("rst_idx",   issue_idx,   0);
    checkOutput("rst_stall", stall_cnt,   0);
    checkOutput("rst_any",   any_req,     1);
    checkOutput("rst_fire",  issue_fire,  0);
    req = 16'h0000;
    issue_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_rel_valid", issue_valid, 0);
  endtask

  initial begin
    #1;
    doReset();

    // Latency: IDLE, req rises, offer one cycle later
    applyStimulus("lat",      16'h0010, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
    applyStimulus("lat_fire", 16'h0010, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);

    // Round-robin: RS clears each fired bit and re-raises it a cycle later
    doReset();
    applyStimulus("rr0", 16'h8101, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    applyStimulus("rr1", 16'h8101, 1'b1, 1'b0, 1'b1, 1'b1, 4'd8);
    applyStimulus("rr2", 16'h8100, 1'b1, 1'b0, 1'b1, 1'b1, 4'd15);
    applyStimulus("rr3", 16'h8001, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    applyStimulus("rr4", 16'h0101, 1'b1, 1'b0, 1'b1, 1'b1, 4'd8);
    applyStimulus("rr5", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);

    // Backpressure: offer idx 3 then hold five cycles
    doReset();
    applyStimulus("bp_offer", 16'h0008, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
    for (int i = 0; i < 5; i++)
      applyStimulus($sformatf("bp_hold%0d", i), 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
`ifdef RS_ISSUE_ARB_STALL_CNT_EN
    checkOutput("bp_stall", stall_cnt, 5);
`else
    checkOutput("bp_stall", stall_cnt, 0);
`endif
    applyStimulus("bp_fire", 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4);
`ifdef RS_ISSUE_ARB_STALL_CNT_EN
    checkOutput("bp_stall_after", stall_cnt, 5);
`else
    checkOutput("bp_stall_after", stall_cnt, 0);
`endif

    // Wrap-around: firing idx 14 leaves ptr at 15
    doReset();
    applyStimulus("wr_offer", 16'h4000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd14);
    applyStimulus("wr_fire",  16'h4000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    applyStimulus("wr_next",  16'h0006, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);

    // Cancel: entry squashed while the FU is not ready
    doReset();
    applyStimulus("cn_offer", 16'h0080, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
    applyStimulus("cn_drop",  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Flush together with fire: fire counts, ptr stays at 0
    doReset();
    applyStimulus("fl_offer", 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
    applyStimulus("fl_fire",  16'h0004, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus("fl_idle",  16'h0009, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus("fl_rearb", 16'h0009, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);

    // Reset while an offer is pending drops it
    doReset();

`ifdef RS_ISSUE_ARB_STALL_CNT_EN
    applyStimulus("sat_offer", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    repeat (70000) @(posedge clk);
    #1;
    checkOutput("sat_stall", stall_cnt, 16'hFFFF);
    checkOutput("sat_valid", issue_valid, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rs_issue_arbiter.md
# rs_issue_arbiter

Issue arbiter for one 16-entry reservation station in the out-of-order core. Takes the per-entry ready vector, reduces it to a single any-ready flag (the 16-input OR reduction), and selects one entry per issue using a rotating round-robin pointer. It offers the selected entry to the functional unit over a valid/ready handshake. The grant is held stable until accepted, cancelled, or flushed.

## Interface
Parameters:
- N, 16, number of RS entries; only 16 is supported.
- IDX_W, 4, width of the entry index (log2 N).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  16  per-entry ready-to-issue; bit i high means entry i is ready.
- flush  in  1  synchronous pipeline flush (mispredict squash).
- any_req  out  1  combinational OR of all req bits.
- issue_valid  out  1  registered; an offer is present.
- issue_ready  in  1  the functional unit accepts the offer this cycle.
- issue_grant  out  16  registered one-hot grant; zero when issue_valid is low.
- issue_idx  out  4  binary index of issue_grant; 0 when idle.
- issue_fire  out  1  combinational; issue_valid & issue_ready.
- stall_cnt  out  16  offer-stall counter (see Configuration).

## Operation
- State machine has two states, IDLE and OFFER.
- Round-robin pointer ptr (4 bits):
  - Reset value is 0.
  - Search order is ptr, ptr+1, …, 15, 0, …, ptr-1, wrapping mod 16.
  - The first set bit in that order wins.
- IDLE:
  - If any_req is high and flush is low, register the winner into issue_grant/issue_idx and go to OFFER.
  - Otherwise stay in IDLE.
- OFFER, in priority order:
  1. flush → IDLE; grant cleared; ptr unchanged.
  2. Cancel: req[issue_idx] low and issue_ready low → IDLE; grant cleared; ptr unchanged. Handles an entry squashed in place.
  3. issue_fire → ptr ← issue_idx+1 (mod 16). Re-arbitrate over req & ~issue_grant starting from the new ptr.
     - Winner found: stay in OFFER with the new grant.
     - No winner: go to IDLE.
  4. Otherwise hold; grant, idx and ptr are unchanged.
- The RS clears the fired entry's req bit no later than the cycle after issue_fire. Masking with ~issue_grant prevents that entry being re-picked.
- issue_ready high while issue_valid is low has no effect.
- issue_grant is always one-hot or zero.
- issue_idx always equals the encoded issue_grant.

## Timing
- Reset (asynchronous, reset_n low):
  - State is IDLE.
  - issue_valid=0, issue_grant=0, issue_idx=0, ptr=0, stall_cnt=0.
  - Deasserting reset mid-offer leaves everything idle; the offer is dropped.
- Latency: req rising in cycle t gives issue_valid in cycle t+1, provided the arbiter was IDLE.
- Throughput: one issue per cycle while requests remain (back-to-back fire, no bubble).
- Flush in the same cycle as issue_fire: the fire still counts, because the FU has sampled it. The state still goes to IDLE and ptr does not advance.
- any_req and issue_fire are combinational. All other outputs are registered.

## Configuration
- Macro: RS_ISSUE_ARB_STALL_CNT_EN.
- Defined:
  - stall_cnt increments each cycle in which issue_valid is 1 and issue_ready is 0.
  - It saturates at 0xFFFF.
  - Only reset clears it; flush does not.
- Undefined:
  - No counter logic.
  - The stall_cnt port remains and is tied to 16'h0000.

## Test plan
- Reset and latency:
  - Hold reset_n low with req=16'hFFFF → all outputs 0.
  - Release reset, keep req=16'h0010 → issue_valid=1 and issue_idx=4 one cycle later.
- Round-robin rotation:
  - req=16'h8101 held, issue_ready=1 constant, RS clears each fired bit and re-raises it one cycle later.
  - Required grant sequence: 0, 8, 15, 0.
  - issue_fire every cycle.
- Backpressure hold:
  - Offer idx 3; issue_ready=0 for 5 cycles while req=16'hFFFF.
  - Grant stays 16'h0008.
  - With RS_ISSUE_ARB_STALL_CNT_EN defined, stall_cnt=5 afterwards; without it, stall_cnt=0.
- Wrap-around:
  - Set ptr=15 by firing idx 14, then req=16'h0006 → next grant is idx 1.
- Cancel and flush:
  - Offer idx 7, drop req[7] with issue_ready=0 → issue_valid=0 next cycle.
  - Offer idx 2, assert flush together with issue_ready=1 → one fire, then IDLE; the next arbitration starts from the old ptr.
- Saturation (macro on): hold issue_ready=0 for 70000 cycles with an offer pending → stall_cnt=16'hFFFF.
